// File: rtl/bottle_change_ctrl.sv
// Bottle change controller: stops pill feeding on a bottle-full pulse, runs the
// conveyor to swap bottles, keeps a BCD count of filled bottles and flags jams.
module bottle_change_ctrl #(
    parameter int BATCH       = 12,
    parameter int MOVE_CYC    = 50,
    parameter int TIMEOUT_CYC = 500,
    parameter int CW          = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cont_set,
    input  logic       bottle_full,
    input  logic       bottle_sensor,
    input  logic       clear_batch,
    output logic       feed_en,
    output logic       conveyor_on,
    output logic [7:0] bottle_cnt,
    output logic       batch_done,
    output logic       fault
);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        MOVE_OUT,
        WAIT_IN,
        DONE,
        FAULT
    } state_t;

    localparam logic [7:0]    BATCH_BCD    = 8'(((BATCH / 10) << 4) | (BATCH % 10));
    localparam logic [CW-1:0] MOVE_LAST    = CW'(MOVE_CYC - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYC - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    bcd_q, bcd_d;
    logic          feed_en_q;
    logic          conveyor_q;
    logic          batch_done_q;
    logic          fault_q;

    // Two-digit BCD increment that wraps 99 back to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] ones;
        logic [3:0] tens;
        ones = v[3:0];
        tens = v[7:4];
        if (ones == 4'd9) begin
            ones = 4'd0;
            tens = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        end else begin
            ones = ones + 4'd1;
        end
        return {tens, ones};
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        case (state_q)
            IDLE: begin
                if (cont_set && bottle_full == 1'b0 && bottle_sensor) begin
                    state_d = FILL;
                end else if (cont_set && bottle_sensor) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                // The pill has already dropped, so a full pulse counts even while paused.
                if (bottle_full) begin
                    bcd_d   = bcd_inc(bcd_q);
                    cnt_d   = '0;
                    state_d = (bcd_d == BATCH_BCD) ? DONE : MOVE_OUT;
                end
            end
            MOVE_OUT: begin
                if (cnt_q == MOVE_LAST) begin
                    state_d = WAIT_IN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_IN: begin
                // A bottle arriving on the timeout cycle still counts as arrived.
                if (bottle_sensor) begin
                    state_d = FILL;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = FAULT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (clear_batch) begin
                    state_d = IDLE;
                    bcd_d   = 8'h00;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bcd_q        <= 8'h00;
            feed_en_q    <= 1'b0;
            conveyor_q   <= 1'b0;
            batch_done_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bcd_q        <= bcd_d;
            feed_en_q    <= (state_d == FILL) && cont_set;
            conveyor_q   <= (state_d == MOVE_OUT) || (state_d == WAIT_IN);
            batch_done_q <= (state_d == DONE);
            fault_q      <= (state_d == FAULT);
        end
    end

    assign feed_en     = feed_en_q;
    assign conveyor_on = conveyor_q;
    assign bottle_cnt  = bcd_q;
    assign batch_done  = batch_done_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_bottle_change_ctrl.sv
// Directed bench for bottle_change_ctrl: a vector table for the main flow plus
// hand sequences for timeout/sensor race, held pulses and BCD carry.
module tb_bottle_change_ctrl;

    logic clk;
    logic rst;
    logic contSet;
    logic bottleFull;
    logic bottleSensor;
    logic clearBatch;

    logic       feedA, convA, doneA, faultA;
    logic [7:0] cntA;
    logic       feedB, convB, doneB, faultB;
    logic [7:0] cntB;

    int checks;
    int failures;

    typedef struct packed {
        logic       rst;
        logic       cont;
        logic       full;
        logic       sensor;
        logic       clear;
        logic       feedEn;
        logic       conv;
        logic [7:0] cnt;
        logic       done;
        logic       fault;
    } vec_t;

    vec_t vecs[$];

    bottle_change_ctrl #(.BATCH(3), .MOVE_CYC(4), .TIMEOUT_CYC(10), .CW(10)) dutA (
        .clk(clk), .rst(rst), .cont_set(contSet), .bottle_full(bottleFull),
        .bottle_sensor(bottleSensor), .clear_batch(clearBatch),
        .feed_en(feedA), .conveyor_on(convA), .bottle_cnt(cntA),
        .batch_done(doneA), .fault(faultA)
    );

    bottle_change_ctrl #(.BATCH(99), .MOVE_CYC(4), .TIMEOUT_CYC(10), .CW(10)) dutB (
        .clk(clk), .rst(rst), .cont_set(contSet), .bottle_full(bottleFull),
        .bottle_sensor(bottleSensor), .clear_batch(clearBatch),
        .feed_en(feedB), .conveyor_on(convB), .bottle_cnt(cntB),
        .batch_done(doneB), .fault(faultB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic r, input logic c, input logic f, input logic s,
                                input logic k, input logic fe, input logic co,
                                input logic [7:0] cn, input logic bd, input logic ft);
        vec_t v;
        v = '{rst: r, cont: c, full: f, sensor: s, clear: k,
              feedEn: fe, conv: co, cnt: cn, done: bd, fault: ft};
        return v;
    endfunction

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic applyStimulus(input logic r, input logic c, input logic f,
                                 input logic s, input logic k);
        rst          = r;
        contSet      = c;
        bottleFull   = f;
        bottleSensor = s;
        clearBatch   = k;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic useB, input logic fe,
                               input logic co, input logic [7:0] cn, input logic bd,
                               input logic ft);
        logic [11:0] got;
        logic [11:0] want;
        got  = useB ? {feedB, convB, cntB, doneB, faultB}
                    : {feedA, convA, cntA, doneA, faultA};
        want = {fe, co, cn, bd, ft};
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s: got feed=%b conv=%b cnt=%h done=%b fault=%b, want feed=%b conv=%b cnt=%h done=%b fault=%b",
                     name, got[11], got[10], got[9:2], got[1], got[0],
                     want[11], want[10], want[9:2], want[1], want[0]);
        end
    endtask

    initial begin
        logic [7:0] expCnt;
        checks       = 0;
        failures     = 0;
        rst          = 1'b0;
        contSet      = 1'b0;
        bottleFull   = 1'b0;
        bottleSensor = 1'b0;
        clearBatch   = 1'b0;

        // Bottle 1: fill, exact 4-cycle move (sensor ignored), sensor on wait cycle 3
        vecs.push_back(mk(1,0,0,0,0, 0,0,8'h00,0,0));
        vecs.push_back(mk(0,1,0,1,0, 1,0,8'h00,0,0));
        vecs.push_back(mk(0,1,1,1,0, 0,1,8'h01,0,0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0,1,0,1,0, 0,1,8'h01,0,0));
        for (int i = 0; i < 2; i++) vecs.push_back(mk(0,1,0,0,0, 0,1,8'h01,0,0));
        vecs.push_back(mk(0,1,0,1,0, 1,0,8'h01,0,0));
        // Bottles 2 and 3, then batch done and clear
        vecs.push_back(mk(0,1,1,1,0, 0,1,8'h02,0,0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0,1,0,0,0, 0,1,8'h02,0,0));
        vecs.push_back(mk(0,1,0,1,0, 1,0,8'h02,0,0));
        vecs.push_back(mk(0,1,1,1,0, 0,0,8'h03,1,0));
        vecs.push_back(mk(0,1,1,1,0, 0,0,8'h03,1,0));
        vecs.push_back(mk(0,0,0,0,0, 0,0,8'h03,1,0));
        vecs.push_back(mk(0,0,0,0,1, 0,0,8'h00,0,0));
        vecs.push_back(mk(0,0,1,0,1, 0,0,8'h00,0,0));
        // Timeout: 10 wait cycles with no bottle, then fault is sticky until reset
        vecs.push_back(mk(0,1,0,1,0, 1,0,8'h00,0,0));
        vecs.push_back(mk(0,1,1,1,0, 0,1,8'h01,0,0));
        for (int i = 0; i < 13; i++) vecs.push_back(mk(0,1,0,0,0, 0,1,8'h01,0,0));
        vecs.push_back(mk(0,1,0,0,0, 0,0,8'h01,0,1));
        vecs.push_back(mk(0,1,0,1,0, 0,0,8'h01,0,1));
        vecs.push_back(mk(0,1,0,1,1, 0,0,8'h01,0,1));
        vecs.push_back(mk(1,0,0,0,0, 0,0,8'h00,0,0));
        // Pause in FILL, pulse while paused, move completes with cont_set low
        vecs.push_back(mk(0,1,0,1,0, 1,0,8'h00,0,0));
        vecs.push_back(mk(0,0,0,1,0, 0,0,8'h00,0,0));
        vecs.push_back(mk(0,0,0,0,0, 0,0,8'h00,0,0));
        vecs.push_back(mk(0,1,0,0,0, 1,0,8'h00,0,0));
        vecs.push_back(mk(0,0,0,0,0, 0,0,8'h00,0,0));
        vecs.push_back(mk(0,0,1,0,0, 0,1,8'h01,0,0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0,0,0,0,0, 0,1,8'h01,0,0));
        vecs.push_back(mk(0,0,0,1,0, 0,0,8'h01,0,0));
        vecs.push_back(mk(0,1,0,1,0, 1,0,8'h01,0,0));
        // Reset in the middle of a move
        vecs.push_back(mk(0,1,1,1,0, 0,1,8'h02,0,0));
        vecs.push_back(mk(0,1,0,1,0, 0,1,8'h02,0,0));
        vecs.push_back(mk(1,1,0,1,0, 0,0,8'h00,0,0));
        vecs.push_back(mk(0,0,0,1,0, 0,0,8'h00,0,0));
        vecs.push_back(mk(0,1,0,0,0, 0,0,8'h00,0,0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].cont, vecs[i].full, vecs[i].sensor, vecs[i].clear);
            checkOutput($sformatf("vec%0d", i), 1'b0, vecs[i].feedEn, vecs[i].conv,
                        vecs[i].cnt, vecs[i].done, vecs[i].fault);
        end

        // Sensor arriving on the last wait cycle beats the timeout
        applyStimulus(1,0,0,0,0);
        applyStimulus(0,1,0,1,0);
        applyStimulus(0,1,1,0,0);
        for (int i = 0; i < 4; i++) applyStimulus(0,1,0,0,0);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(0,1,0,0,0);
            checkOutput($sformatf("waitNoFault%0d", i + 2), 1'b0, 0,1,8'h01,0,0);
        end
        applyStimulus(0,1,0,1,0);
        checkOutput("sensorBeatsTimeout", 1'b0, 1,0,8'h01,0,0);

        // bottle_full held high for three cycles counts only once
        for (int i = 0; i < 3; i++) applyStimulus(0,1,1,0,0);
        checkOutput("heldPulseOnce", 1'b0, 0,1,8'h02,0,0);

        // BCD carry on the 99-bottle instance, with pulses outside FILL ignored
        applyStimulus(1,0,0,0,0);
        applyStimulus(0,0,1,0,0);
        checkOutput("fullInIdleIgnored", 1'b1, 0,0,8'h00,0,0);
        for (int b = 1; b <= 10; b++) begin
            expCnt = 8'(((b / 10) << 4) | (b % 10));
            applyStimulus(0,1,0,1,0);
            applyStimulus(0,1,1,1,0);
            checkOutput($sformatf("bcdCount%0d", b), 1'b1, 0,1,expCnt,0,0);
            applyStimulus(0,1,1,0,0);
            checkOutput($sformatf("fullInMoveIgnored%0d", b), 1'b1, 0,1,expCnt,0,0);
            for (int i = 0; i < 3; i++) applyStimulus(0,1,0,0,0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
